// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register pending-write counters that flag read-after-write hazards
// at issue and retire on write-back. X31 (ZREG) is the zero register and is never tracked.
module reg_scoreboard #(
  parameter int unsigned NREG      = 32,
  parameter int unsigned AW        = 5,
  parameter int unsigned CW        = 2,
  parameter int unsigned ZREG      = 31,
  parameter bit          WB_BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            iss_valid,
  input  logic            iss_wen,
  input  logic [AW-1:0]   iss_rd,
  input  logic [AW-1:0]   iss_rn,
  input  logic [AW-1:0]   iss_rm,
  input  logic [AW-1:0]   iss_rt,
  input  logic            reg2loc,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd,
  output logic            stall,
  output logic            issue_ok,
  output logic [NREG-1:0] busy,
  output logic            err_uflow
);

  localparam logic [AW-1:0] ZAddr  = AW'(ZREG);
  localparam logic [CW-1:0] CntOne = CW'(1);
  localparam logic [CW-1:0] CntMax = '1;

  logic [CW-1:0]   r_cnt [NREG];
  logic            r_err;

  logic [AW-1:0]   w_src2;
  logic [CW-1:0]   w_cnt_rn, w_cnt_s2, w_cnt_rd, w_cnt_wb;
  logic            w_byp_rn, w_byp_s2;
  logic            w_hz_rn, w_hz_s2, w_full, w_uflow;
  logic [NREG-1:0] w_inc, w_dec;

  assign w_src2   = reg2loc ? iss_rt : iss_rm;
  assign w_cnt_rn = r_cnt[iss_rn];
  assign w_cnt_s2 = r_cnt[w_src2];
  assign w_cnt_rd = r_cnt[iss_rd];
  assign w_cnt_wb = r_cnt[wb_rd];

  // A final retire in the same cycle releases a single pending reader
  assign w_byp_rn = WB_BYPASS & wb_valid & (wb_rd == iss_rn) & (w_cnt_rn == CntOne);
  assign w_byp_s2 = WB_BYPASS & wb_valid & (wb_rd == w_src2) & (w_cnt_s2 == CntOne);

  assign w_hz_rn  = (iss_rn != ZAddr) & (w_cnt_rn != '0) & ~w_byp_rn;
  assign w_hz_s2  = (w_src2 != ZAddr) & (w_cnt_s2 != '0) & ~w_byp_s2;
  // Deliberately blind to a same-cycle retire so the counter can never overflow
  assign w_full   = iss_wen & (iss_rd != ZAddr) & (w_cnt_rd == CntMax);

  assign stall    = iss_valid & (w_hz_rn | w_hz_s2 | w_full);
  assign issue_ok = iss_valid & ~stall;
  assign w_uflow  = wb_valid & (wb_rd != ZAddr) & (w_cnt_wb == '0);

  always_comb begin
    w_inc = '0;
    w_dec = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (i != ZREG) begin
        w_inc[i] = issue_ok & iss_wen & (iss_rd == AW'(i));
        w_dec[i] = wb_valid & (wb_rd == AW'(i)) & (r_cnt[i] != '0);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        r_cnt[i] <= '0;
      end
      r_err <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NREG; i++) begin
        if (w_inc[i] && !w_dec[i]) begin
          r_cnt[i] <= r_cnt[i] + CntOne;
        end else if (w_dec[i] && !w_inc[i]) begin
          r_cnt[i] <= r_cnt[i] - CntOne;
        end
      end
      r_err <= r_err | w_uflow;
    end
  end

  always_comb begin
    busy = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      busy[i] = (r_cnt[i] != '0);
    end
  end

  assign err_uflow = r_err;

endmodule
